id_stage_seq: RTL and testbench
===============================

# id_stage_seq

Parametrised instruction-decode stage with an integrated ID/EXE pipeline register, a write-through register file and a two-micro-op sequencer for ARM long multiply (UMULL/SMULL). It sits between the IF/ID register and the execute stage. It also takes over the dest-plus-one freeze that previously lived in the control unit. Outputs are registered, so decode-to-EXE latency is exactly one cycle.

## Interface
- DATA_W, 32, datapath width of PC, register file and operand values
- LONG_MUL, 1, 1 = split long multiply into lo/hi micro-ops; 0 = decode long multiply as a bubble
- REG_INIT_INDEX, 1, 1 = register i resets to i; 0 = all registers reset to 0
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- pc_in  in  DATA_W  PC of the instruction in ID
- instruction  in  32  instruction word
- instr_valid  in  1  instruction word is valid
- status  in  4  {N,Z,C,V} from the status register
- hazard  in  1  hazard unit stall request
- flush  in  1  branch taken in EXE; kill the ID contents
- wb_wb_en  in  1  write-back enable
- wb_dest  in  4  write-back register
- wb_value  in  DATA_W  write-back data
- pc  out  DATA_W  registered PC
- valid  out  1  registered: the EXE slot holds a real micro-op
- mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm  out  1 each  registered controls
- exec_cmd  out  4  registered ALU command
- val_rn, val_rm  out  DATA_W  registered operands
- signed_immed_24  out  24  registered instruction[23:0]
- shift_operand  out  12  registered instruction[11:0]
- dest  out  4  registered destination
- mul_hi  out  1  registered: micro-op is the high half of a long multiply
- rn, src2  out  4 each  combinational read addresses, for the hazard unit
- two_src  out  1  combinational: decoded op reads src2
- freeze  out  1  combinational: IF must hold PC and instruction next cycle

## Operation
- Field mapping: cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0].
- Long multiply: mode = 00, [27:23] = 00001, [7:4] = 1001.
- Read addresses:
  - Long multiply: rn = [3:0], src2 = [11:8].
  - Store: rn = Rn, src2 = Rd.
  - Otherwise: rn = Rn, src2 = Rm.
- two_src = ~I | store | long multiply.
- exec_cmd for mode 00, by opcode:
  - MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101
  - AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110
  - All other opcodes produce a bubble.
- CMP and TST: wb_en = 0, status_w_en = 1. Other mode-00 ops: status_w_en = S.
- Mode 01 (LDR/STR): exec_cmd = 0010, imm = 1.
  - S = 1 is LDR: mem_r_en = 1, wb_en = 1.
  - S = 0 is STR: mem_w_en = 1.
- Mode 10 (B): branch_taken = 1, all other controls 0.
- Long multiply micro-ops:
  - lo: exec_cmd = 1010, dest = Rd, mul_hi = 0.
  - hi: exec_cmd = 1011, dest = (Rd + 1) mod 16, mul_hi = 1.
  - Both: wb_en = 1, status_w_en = S.
- Condition check uses the standard ARM table (EQ … AL). cond = 1111 fails. A failing condition produces a bubble.
- Bubble: valid and every control bit 0. Data fields still load.
- Register file: 16 × DATA_W, written on the clk edge when wb_wb_en = 1. A read whose address equals wb_dest while wb_wb_en = 1 returns wb_value (write-through).
- Sequencer states and transitions (IDLE, HI):
  - IDLE: a valid long multiply with the condition passing, no hazard and no flush issues lo, sets freeze = 1 and goes to HI.
  - HI: issues hi, freeze = 0, returns to IDLE.
  - HI with hazard: issues a bubble, stays in HI, keeps freeze = 1.
  - HI with flush: issues a bubble, goes to IDLE, freeze = 0.
  - LONG_MUL = 0: the sequencer never leaves IDLE.
- Priority each edge: rst > flush > hazard > decode.
  - flush or hazard loads a bubble.
  - instr_valid = 0 loads a bubble.

## Timing
- Reset: all registered outputs are 0, the sequencer is in IDLE and freeze = 0. Register i resets to i, or to 0, per REG_INIT_INDEX.
- Decode is combinational; the result appears on the outputs after the next rising edge (1-cycle latency).
- A long multiply occupies 2 EXE slots (lo then hi) in consecutive cycles when there are no stalls.
- freeze is combinational from the state and the current instruction. It is asserted only in IDLE for an issuing long multiply, and in HI while hazard = 1.
- A write-back in the same cycle as a read is visible in val_rn/val_rm at the next edge.
- rst asserted in HI aborts the sequence and the hi micro-op is never issued.

## Test plan
- Reset, then idle cycles -> all outputs 0, freeze = 0; read R5 -> val_rn = 5 when REG_INIT_INDEX = 1.
- ADDS R1,R2,R3 (0xE0921003) with AL -> after 1 edge: valid = 1, exec_cmd = 0010, wb_en = 1, status_w_en = 1, dest = 1.
- UMULL R4,R5,R6,R7 (0xE0854796) -> edge 1: lo, dest = 4, freeze was 1; edge 2: hi, dest = 5, mul_hi = 1.
- Same UMULL with hazard = 1 during HI for 2 cycles -> 2 bubbles, freeze held at 1, then hi issues with dest = 5.
- UMULL with flush = 1 in HI -> bubble, state IDLE, freeze = 0; the next instruction decodes normally.
- wb_wb_en = 1, wb_dest = 2, wb_value = 0xDEADBEEF, with ADD reading R2 in the same cycle -> val_rn = 0xDEADBEEF; BEQ with Z = 0 -> bubble.

Source files
------------

// File: rtl/id_stage_seq.sv
// Decode stage with ID/EXE register, write-through register file and a
// two-micro-op sequencer that splits long multiplies into lo/hi halves.
//
//   state  | meaning
//   IDLE   | normal decode; an issuing long multiply emits lo and freezes IF
//   HI     | long multiply lo has issued; hi issues next unless stalled/flushed
module id_stage_seq #(
    parameter int DATA_W         = 32,
    parameter bit LONG_MUL       = 1'b1,
    parameter bit REG_INIT_INDEX = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic [3:0]        status,
    input  logic              hazard,
    input  logic              flush,
    input  logic              wb_wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [DATA_W-1:0] pc,
    output logic              valid,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic              status_w_en,
    output logic              branch_taken,
    output logic              imm,
    output logic [3:0]        exec_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [23:0]       signed_immed_24,
    output logic [11:0]       shift_operand,
    output logic [3:0]        dest,
    output logic              mul_hi,
    output logic [3:0]        rn,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              freeze
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HI   = 1'b1;

    logic [0:0] state, state_nxt;

    logic [3:0] cond, opcode, rn_f, rd_f, rm_f;
    logic [1:0] mode;
    logic       i_bit, s_bit, is_lmul, is_store, cond_pass;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn_f   = instruction[19:16];
    assign rd_f   = instruction[15:12];
    assign rm_f   = instruction[3:0];

    assign is_lmul  = (instruction[27:23] == 5'b00001) && (instruction[7:4] == 4'b1001);
    assign is_store = (mode == 2'b01) && !s_bit;

    assign rn      = is_lmul ? instruction[3:0] : rn_f;
    assign src2    = is_lmul ? instruction[11:8] : (is_store ? rd_f : rm_f);
    assign two_src = ~i_bit | is_store | is_lmul;

    assign {flag_n, flag_z, flag_c, flag_v} = status;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic       d_valid, d_mem_r, d_mem_w, d_wb, d_sw, d_br, d_imm;
    logic [3:0] d_cmd;

    always_comb begin
        d_valid = 1'b0;
        d_mem_r = 1'b0;
        d_mem_w = 1'b0;
        d_wb    = 1'b0;
        d_sw    = 1'b0;
        d_br    = 1'b0;
        d_imm   = 1'b0;
        d_cmd   = 4'b0000;
        if (cond_pass) begin
            if (is_lmul) begin
                if (LONG_MUL) begin
                    d_valid = 1'b1;
                    d_cmd   = 4'b1010;
                    d_wb    = 1'b1;
                    d_sw    = s_bit;
                end
            end else begin
                case (mode)
                    2'b00: begin
                        d_valid = 1'b1;
                        d_wb    = 1'b1;
                        d_sw    = s_bit;
                        d_imm   = i_bit;
                        case (opcode)
                            4'b1101: d_cmd = 4'b0001;
                            4'b1111: d_cmd = 4'b1001;
                            4'b0100: d_cmd = 4'b0010;
                            4'b0101: d_cmd = 4'b0011;
                            4'b0010: d_cmd = 4'b0100;
                            4'b0110: d_cmd = 4'b0101;
                            4'b0000: d_cmd = 4'b0110;
                            4'b1100: d_cmd = 4'b0111;
                            4'b0001: d_cmd = 4'b1000;
                            4'b1010: begin
                                d_cmd = 4'b0100;
                                d_wb  = 1'b0;
                                d_sw  = 1'b1;
                            end
                            4'b1000: begin
                                d_cmd = 4'b0110;
                                d_wb  = 1'b0;
                                d_sw  = 1'b1;
                            end
                            default: begin
                                d_valid = 1'b0;
                                d_wb    = 1'b0;
                                d_sw    = 1'b0;
                                d_imm   = 1'b0;
                            end
                        endcase
                    end
                    2'b01: begin
                        d_valid = 1'b1;
                        d_cmd   = 4'b0010;
                        d_imm   = 1'b1;
                        d_mem_r = s_bit;
                        d_wb    = s_bit;
                        d_mem_w = !s_bit;
                    end
                    2'b10: begin
                        d_valid = 1'b1;
                        d_br    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic issue_lo;
    assign issue_lo = (state == S_IDLE) && d_valid && is_lmul && instr_valid && !hazard && !flush;
    assign freeze   = !rst && (issue_lo || ((state == S_HI) && hazard && !flush));

    logic       n_valid, n_mem_r, n_mem_w, n_wb, n_sw, n_br, n_imm, n_mul_hi;
    logic [3:0] n_cmd, n_dest;

    always_comb begin
        n_valid   = 1'b0;
        n_mem_r   = 1'b0;
        n_mem_w   = 1'b0;
        n_wb      = 1'b0;
        n_sw      = 1'b0;
        n_br      = 1'b0;
        n_imm     = 1'b0;
        n_mul_hi  = 1'b0;
        n_cmd     = 4'b0000;
        n_dest    = rd_f;
        state_nxt = state;
        if (state == S_HI) begin
            // IF holds the long multiply while in HI, so its fields are still on the input
            if (flush) begin
                state_nxt = S_IDLE;
            end else if (!hazard) begin
                n_valid   = 1'b1;
                n_cmd     = 4'b1011;
                n_wb      = 1'b1;
                n_sw      = s_bit;
                n_mul_hi  = 1'b1;
                n_dest    = rd_f + 4'd1;
                state_nxt = S_IDLE;
            end
        end else if (!flush && !hazard && instr_valid) begin
            n_valid = d_valid;
            n_mem_r = d_mem_r;
            n_mem_w = d_mem_w;
            n_wb    = d_wb;
            n_sw    = d_sw;
            n_br    = d_br;
            n_imm   = d_imm;
            n_cmd   = d_cmd;
            if (issue_lo) state_nxt = S_HI;
        end
    end

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] rd_rn, rd_src2;

    assign rd_rn   = (wb_wb_en && (wb_dest == rn))   ? wb_value : regs[rn];
    assign rd_src2 = (wb_wb_en && (wb_dest == src2)) ? wb_value : regs[src2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= REG_INIT_INDEX ? DATA_W'(i) : '0;
            end
        end else if (wb_wb_en) begin
            regs[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= '0;
            valid           <= 1'b0;
            mem_r_en        <= 1'b0;
            mem_w_en        <= 1'b0;
            wb_en           <= 1'b0;
            status_w_en     <= 1'b0;
            branch_taken    <= 1'b0;
            imm             <= 1'b0;
            mul_hi          <= 1'b0;
            exec_cmd        <= 4'b0000;
            dest            <= 4'b0000;
            val_rn          <= '0;
            val_rm          <= '0;
            signed_immed_24 <= '0;
            shift_operand   <= '0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_in;
            valid           <= n_valid;
            mem_r_en        <= n_mem_r;
            mem_w_en        <= n_mem_w;
            wb_en           <= n_wb;
            status_w_en     <= n_sw;
            branch_taken    <= n_br;
            imm             <= n_imm;
            mul_hi          <= n_mul_hi;
            exec_cmd        <= n_cmd;
            dest            <= n_dest;
            val_rn          <= rd_rn;
            val_rm          <= rd_src2;
            signed_immed_24 <= instruction[23:0];
            shift_operand   <= instruction[11:0];
        end
    end

endmodule

// File: tb/tb_id_stage_seq.sv
// Bench for id_stage_seq: directed scenarios then random instruction streams,
// each cycle compared against an instruction-level reference model.
module tb_id_stage_seq;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc_in;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic [3:0]    status;
    logic          hazard, flush, wb_wb_en;
    logic [3:0]    wb_dest;
    logic [DW-1:0] wb_value;
    logic [DW-1:0] pc, val_rn, val_rm;
    logic          valid, mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm, mul_hi;
    logic [3:0]    exec_cmd, dest, rn, src2;
    logic [23:0]   signed_immed_24;
    logic [11:0]   shift_operand;
    logic          two_src, freeze;

    always #5 clk = ~clk;

    id_stage_seq #(.DATA_W(DW), .LONG_MUL(1'b1), .REG_INIT_INDEX(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
        .instr_valid(instr_valid), .status(status), .hazard(hazard), .flush(flush),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .pc(pc), .valid(valid), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
        .status_w_en(status_w_en), .branch_taken(branch_taken), .imm(imm),
        .exec_cmd(exec_cmd), .val_rn(val_rn), .val_rm(val_rm),
        .signed_immed_24(signed_immed_24), .shift_operand(shift_operand), .dest(dest),
        .mul_hi(mul_hi), .rn(rn), .src2(src2), .two_src(two_src), .freeze(freeze)
    );

    typedef struct {
        logic          valid, mem_r, mem_w, wb, sw, br, imm, mul_hi;
        logic [3:0]    cmd, dest;
        logic [DW-1:0] pc, va, vb;
        logic [23:0]   s24;
        logic [11:0]   sh;
    } exp_t;

    // Reference state: architectural registers and "hi half still owed"
    logic [DW-1:0] m_regs [16];
    bit            m_hi;
    logic [4:0]    alu_map [16];
    bit            alu_flag_only [16];

    int   n_vec = 0;
    int   n_err = 0;
    logic last_fz;
    logic obs_fz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
        bit n, z, cf, v;
        {n, z, cf, v} = st;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [3:0] a);
        return (wb_wb_en && wb_dest == a) ? wb_value : m_regs[a];
    endfunction

    task automatic predict(output exp_t e, output logic fz, output bit nxt_hi,
                           output logic [3:0] e_rn, output logic [3:0] e_src2, output logic e_two);
        logic [31:0] w;
        bit lmul, store;
        w     = instruction;
        lmul  = (w[27:23] == 5'b00001) && (w[7:4] == 4'b1001);
        store = (w[27:26] == 2'b01) && !w[20];
        e_rn   = lmul ? w[3:0] : w[19:16];
        e_src2 = lmul ? w[11:8] : (store ? w[15:12] : w[3:0]);
        e_two  = !w[25] || store || lmul;
        e = '{default: '0};
        fz = 1'b0;
        nxt_hi = 1'b0;
        if (!rst) begin
            e.pc = pc_in;
            e.va = m_read(e_rn);
            e.vb = m_read(e_src2);
            e.s24 = w[23:0];
            e.sh = w[11:0];
            e.dest = w[15:12];
            if (m_hi) begin
                if (!flush && hazard) begin
                    fz = 1'b1;
                    nxt_hi = 1'b1;
                end else if (!flush) begin
                    e.valid = 1; e.cmd = 4'hB; e.wb = 1; e.sw = w[20]; e.mul_hi = 1;
                    e.dest = 4'(w[15:12] + 4'd1);
                end
            end else if (!flush && !hazard && instr_valid && cond_ok(w[31:28], status)) begin
                if (lmul) begin
                    e.valid = 1; e.cmd = 4'hA; e.wb = 1; e.sw = w[20];
                    fz = 1'b1;
                    nxt_hi = 1'b1;
                end else if (w[27:26] == 2'b00) begin
                    if (alu_map[w[24:21]][4]) begin
                        e.valid = 1;
                        e.cmd = alu_map[w[24:21]][3:0];
                        e.imm = w[25];
                        e.wb = !alu_flag_only[w[24:21]];
                        e.sw = alu_flag_only[w[24:21]] ? 1'b1 : w[20];
                    end
                end else if (w[27:26] == 2'b01) begin
                    e.valid = 1; e.cmd = 4'h2; e.imm = 1;
                    e.mem_r = w[20]; e.wb = w[20]; e.mem_w = !w[20];
                end else if (w[27:26] == 2'b10) begin
                    e.valid = 1; e.br = 1;
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        logic fz, etwo;
        bit nh;
        logic [3:0] ern, es2;
        @(negedge clk);
        #1;
        predict(e, fz, nh, ern, es2, etwo);
        obs_fz = freeze;
        chk({tag, ".freeze"}, 64'(freeze), 64'(fz));
        chk({tag, ".rn"}, 64'(rn), 64'(ern));
        chk({tag, ".src2"}, 64'(src2), 64'(es2));
        chk({tag, ".two_src"}, 64'(two_src), 64'(etwo));
        last_fz = fz;
        @(posedge clk);
        #1;
        chk({tag, ".ctrl"},
            64'({valid, mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm, mul_hi}),
            64'({e.valid, e.mem_r, e.mem_w, e.wb, e.sw, e.br, e.imm, e.mul_hi}));
        if (e.valid || rst) begin
            chk({tag, ".exec_cmd"}, 64'(exec_cmd), 64'(e.cmd));
            chk({tag, ".dest"}, 64'(dest), 64'(e.dest));
        end
        chk({tag, ".pc"}, 64'(pc), 64'(e.pc));
        chk({tag, ".val_rn"}, 64'(val_rn), 64'(e.va));
        chk({tag, ".val_rm"}, 64'(val_rm), 64'(e.vb));
        chk({tag, ".imm24"}, 64'(signed_immed_24), 64'(e.s24));
        chk({tag, ".shop"}, 64'(shift_operand), 64'(e.sh));
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = DW'(i);
            m_hi = 1'b0;
        end else begin
            if (wb_wb_en) m_regs[wb_dest] = wb_value;
            m_hi = nh;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0, 1: w[27:26] = 2'b00;
            2: w[27:26] = 2'b01;
            3: w[27:26] = 2'($urandom_range(2, 3));
            default: begin
                w[27:23] = 5'b00001;
                w[7:4] = 4'b1001;
            end
        endcase
        if ($urandom_range(0, 1) == 1) w[31:28] = 4'hE;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            alu_map[i] = 5'b0;
            alu_flag_only[i] = 1'b0;
            m_regs[i] = DW'(i);
        end
        alu_map[4'b1101] = 5'h11;  // MOV
        alu_map[4'b1111] = 5'h19;  // MVN
        alu_map[4'b0100] = 5'h12;  // ADD
        alu_map[4'b0101] = 5'h13;  // ADC
        alu_map[4'b0010] = 5'h14;  // SUB
        alu_map[4'b0110] = 5'h15;  // SBC
        alu_map[4'b0000] = 5'h16;  // AND
        alu_map[4'b1100] = 5'h17;  // ORR
        alu_map[4'b0001] = 5'h18;  // EOR
        alu_map[4'b1010] = 5'h14;  // CMP
        alu_map[4'b1000] = 5'h16;  // TST
        alu_flag_only[4'b1010] = 1'b1;
        alu_flag_only[4'b1000] = 1'b1;
        m_hi = 1'b0;

        rst = 1; pc_in = '0; instruction = '0; instr_valid = 0; status = 0;
        hazard = 0; flush = 0; wb_wb_en = 0; wb_dest = 0; wb_value = '0;
        cycle("rst0");
        cycle("rst1");
        rst = 0;
        cycle("idle0");
        cycle("idle1");
        chk("idle_valid", 64'(valid), 64'd0);

        instruction = 32'hE0850006; instr_valid = 1; pc_in = 32'h100;
        cycle("read_r5");
        chk("r5_value", 64'(val_rn), 64'd5);

        instruction = 32'hE0921003; pc_in = 32'h104;
        cycle("adds");
        chk("adds_word", 64'({valid, exec_cmd, wb_en, status_w_en, dest}), 64'({1'b1, 4'b0010, 1'b1, 1'b1, 4'd1}));

        instruction = 32'hE0854796; pc_in = 32'h108;
        cycle("umull_lo");
        chk("lo_word", 64'({obs_fz, valid, exec_cmd, dest, mul_hi}), 64'({1'b1, 1'b1, 4'b1010, 4'd4, 1'b0}));
        cycle("umull_hi");
        chk("hi_word", 64'({obs_fz, valid, exec_cmd, dest, mul_hi}), 64'({1'b0, 1'b1, 4'b1011, 4'd5, 1'b1}));

        cycle("umull2_lo");
        hazard = 1;
        cycle("hz0");
        chk("hz0_bubble", 64'({obs_fz, valid}), 64'({1'b1, 1'b0}));
        cycle("hz1");
        chk("hz1_bubble", 64'({obs_fz, valid}), 64'({1'b1, 1'b0}));
        hazard = 0;
        cycle("hz_hi");
        chk("hz_hi_word", 64'({valid, dest, mul_hi}), 64'({1'b1, 4'd5, 1'b1}));

        cycle("umull3_lo");
        flush = 1;
        cycle("fl_hi");
        chk("flush_bubble", 64'({obs_fz, valid}), 64'({1'b0, 1'b0}));
        flush = 0; instruction = 32'hE0921003;
        cycle("after_flush");
        chk("after_flush_word", 64'({valid, exec_cmd, mul_hi}), 64'({1'b1, 4'b0010, 1'b0}));

        wb_wb_en = 1; wb_dest = 2; wb_value = 32'hDEADBEEF; instruction = 32'hE0821003;
        cycle("wt");
        chk("wt_val_rn", 64'(val_rn), 64'hDEADBEEF);
        wb_wb_en = 0;

        instruction = 32'h0A000010; status = 4'b0000;
        cycle("beq_nz");
        chk("beq_nz_bubble", 64'({valid, branch_taken}), 64'({1'b0, 1'b0}));
        status = 4'b0100;
        cycle("beq_z");
        chk("beq_z_taken", 64'({valid, branch_taken}), 64'({1'b1, 1'b1}));
        instruction = 32'hF0821003;
        cycle("nv");
        chk("nv_bubble", 64'(valid), 64'd0);

        instruction = 32'hE0854796;
        cycle("umull4_lo");
        rst = 1;
        cycle("rst_in_hi");
        rst = 0; instruction = 32'hE0921003;
        cycle("post_rst");
        chk("post_rst_word", 64'({valid, mul_hi}), 64'({1'b1, 1'b0}));

        for (int k = 0; k < 400; k++) begin
            if (!last_fz) begin
                instruction = gen_instr();
                instr_valid = ($urandom_range(0, 7) != 0);
            end
            pc_in    = $urandom;
            status   = 4'($urandom_range(0, 15));
            hazard   = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 10) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            wb_wb_en = ($urandom_range(0, 1) == 1);
            wb_dest  = 4'($urandom_range(0, 15));
            wb_value = $urandom;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
